// File: rtl/tap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tap_pkg
// Description : Shared definitions for the multi-channel trigger-tap command
//               executor: command field layout, instruction codes, ctl slice
//               layout and response helpers.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
package tap_pkg;

  // Target code accepted by the executor
  localparam logic [3:0] C_TAP       = 4'h3;

  // Instruction codes
  localparam logic [3:0] I_SET_GT      = 4'd0;
  localparam logic [3:0] I_SET_ET      = 4'd1;
  localparam logic [3:0] I_SET_LT      = 4'd2;
  localparam logic [3:0] I_SET_THR     = 4'd3;
  localparam logic [3:0] I_SET_TRIG_EN = 4'd4;
  localparam logic [3:0] I_GET_THR     = 4'd5;
  localparam logic [3:0] I_GET_FLAGS   = 4'd6;
  localparam logic [3:0] I_RESET_CH    = 4'd7;

  // Channel number that addresses every channel
  localparam logic [6:0] C_TAP_BCAST = 7'h7F;

  // Command field bit positions
  localparam int TGT_LSB   = 28;
  localparam int INSTR_LSB = 24;
  localparam int ERR_BIT   = 23;
  localparam int CH_LSB    = 16;
  localparam int VAL_LSB   = 0;

  // ctl slice layout: {trig_en, lt, et, gt, thr}; flags sit above thr
  localparam int CTL_FLAG_W = 4;
  localparam int FLAG_GT    = 0;
  localparam int FLAG_ET    = 1;
  localparam int FLAG_LT    = 2;
  localparam int FLAG_TRIG  = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Width of one channel slice in the flattened ctl bus
  function automatic int ctl_w(input int thr_w);
    return thr_w + CTL_FLAG_W;
  endfunction

  // Bit position of a flag inside one channel slice
  function automatic int flag_pos(input int thr_w, input int flag);
    return thr_w + flag;
  endfunction

  function automatic logic [3:0] cmd_target(input logic [31:0] c);
    return c[TGT_LSB +: 4];
  endfunction

  function automatic logic [3:0] cmd_instr(input logic [31:0] c);
    return c[INSTR_LSB +: 4];
  endfunction

  function automatic logic [6:0] cmd_ch(input logic [31:0] c);
    return c[CH_LSB +: 7];
  endfunction

  function automatic logic [15:0] cmd_val(input logic [31:0] c);
    return c[VAL_LSB +: 16];
  endfunction

  // Successful SET/RESET_CH: echo the command with the error bit cleared
  function automatic logic [31:0] rsp_ok(input logic [31:0] c);
    logic [31:0] r;
    r = c;
    r[ERR_BIT] = 1'b0;
    return r;
  endfunction

  // Rejected command: echo the command with the error bit set
  function automatic logic [31:0] rsp_err(input logic [31:0] c);
    logic [31:0] r;
    r = c;
    r[ERR_BIT] = 1'b1;
    return r;
  endfunction

  // Successful GET: upper half echoed, readback in the lower half
  function automatic logic [31:0] rsp_get(input logic [31:0] c, input logic [15:0] d);
    return {c[31:16], d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tap_ch_reg.sv
`default_nettype none
// ============================================================================
// Module      : tap_ch_reg
// Description : Control register for one discriminator channel. Holds the
//               GT/ET/LT enables, trigger enable and threshold; applies SET_*
//               and RESET_CH writes presented by the executor.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module tap_ch_reg
  import tap_pkg::*;
#(
  parameter int THR_W    = 14,
  parameter int THR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       sel,
  input  logic [15:0]      val,
  output logic [THR_W+3:0] ctl_o
);

  logic             gt;
  logic             et;
  logic             lt;
  logic             trig_en;
  logic [THR_W-1:0] thr;

  // Upper value bits are ignored when the threshold is narrower than 16 bits
  logic unused_val;
  assign unused_val = ^val;

  // Channel state: reset and RESET_CH both restore the power-on values
  always_ff @(posedge clk) begin
    if (rst || (we && sel == I_RESET_CH[2:0])) begin
      gt      <= 1'b0;
      et      <= 1'b0;
      lt      <= 1'b0;
      trig_en <= 1'b0;
      thr     <= THR_W'(THR_INIT);
    end else if (we) begin
      case (sel)
        I_SET_GT[2:0]:      gt      <= val[0];
        I_SET_ET[2:0]:      et      <= val[0];
        I_SET_LT[2:0]:      lt      <= val[0];
        I_SET_THR[2:0]:     thr     <= val[THR_W-1:0];
        I_SET_TRIG_EN[2:0]: trig_en <= val[0];
        default: ;
      endcase
    end
  end

  assign ctl_o = {trig_en, lt, et, gt, thr};

endmodule
`default_nettype wire

// File: rtl/tap_exe_mc.sv
`default_nettype none
// ============================================================================
// Module      : tap_exe_mc
// Description : Multi-channel trigger-tap command executor. Decodes commands,
//               writes per-channel controls, serves readback, sequences
//               broadcast writes one channel per cycle and reports dropped
//               commands through a sticky overflow flag.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module tap_exe_mc
  import tap_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int THR_W    = 14,
  parameter int THR_INIT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic [31:0]                 cmd,
  output logic [31:0]                 rsp,
  output logic                        rsp_valid,
  output logic                        busy,
  output logic                        ovf,
  output logic [N_CH*(THR_W+4)-1:0]   ctl
);

  localparam int         CW       = ctl_w(THR_W);
  localparam logic [6:0] LAST_IDX = 7'(N_CH - 1);
  localparam logic [7:0] N_CH_V   = 8'(N_CH);

  state_t      state;
  logic [6:0]  idx;
  logic [31:0] bc_cmd;

  logic [3:0]  target;
  logic [3:0]  instr;
  logic [6:0]  ch;
  logic        is_bcast;
  logic        is_get;
  logic        bad_ch;
  logic        err;
  logic        accept;
  logic        single_wr;
  logic        sweeping;
  logic [2:0]  wr_sel;
  logic [15:0] wr_val;

  assign target    = cmd_target(cmd);
  assign instr     = cmd_instr(cmd);
  assign ch        = cmd_ch(cmd);
  assign is_bcast  = (ch == C_TAP_BCAST);
  assign is_get    = (instr == I_GET_THR) || (instr == I_GET_FLAGS);
  assign bad_ch    = ({1'b0, ch} >= N_CH_V) && !is_bcast;
  assign err       = instr[3] || bad_ch || (is_get && is_bcast);
  assign accept    = (state == ST_IDLE) && run && (target == C_TAP);
  assign single_wr = accept && !err && !is_get && !is_bcast;
  assign sweeping  = (state == ST_SWEEP);

  // One shared write bus; during a sweep it carries the latched broadcast
  assign wr_sel = sweeping ? bc_cmd[INSTR_LSB +: 3] : instr[2:0];
  assign wr_val = sweeping ? cmd_val(bc_cmd) : cmd_val(cmd);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic we_k;
    assign we_k = (sweeping && idx == 7'(k)) || (single_wr && ch == 7'(k));

    tap_ch_reg #(
      .THR_W    (THR_W),
      .THR_INIT (THR_INIT)
    ) u_reg (
      .clk   (clk),
      .rst   (rst),
      .we    (we_k),
      .sel   (wr_sel),
      .val   (wr_val),
      .ctl_o (ctl[k*CW +: CW])
    );
  end

  logic [CW-1:0] rd_slice;
  logic [15:0]   rd_data;

  // Readback mux: select the addressed channel slice (pre-edge value)
  always_comb begin
    rd_slice = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch == 7'(k)) rd_slice = ctl[k*CW +: CW];
    end
  end

  assign rd_data = (instr == I_GET_THR) ? 16'(rd_slice[THR_W-1:0])
                                        : {12'b0, rd_slice[CW-1:THR_W]};

  // Command FSM: single commands answer next cycle, broadcasts sweep idx
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      bc_cmd    <= '0;
      rsp       <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (err) begin
              rsp       <= rsp_err(cmd);
              rsp_valid <= 1'b1;
            end else if (is_get) begin
              rsp       <= rsp_get(cmd, rd_data);
              rsp_valid <= 1'b1;
            end else if (is_bcast) begin
              bc_cmd <= cmd;
              idx    <= '0;
              busy   <= 1'b1;
              state  <= ST_SWEEP;
            end else begin
              rsp       <= rsp_ok(cmd);
              rsp_valid <= 1'b1;
            end
          end
        end
        ST_SWEEP: begin
          if (run) ovf <= 1'b1;
          if (idx == LAST_IDX) begin
            rsp       <= rsp_ok(bc_cmd);
            rsp_valid <= 1'b1;
            busy      <= 1'b0;
            idx       <= '0;
            state     <= ST_IDLE;
          end else begin
            idx <= idx + 7'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tap_exe_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_tap_exe_mc
// Description : Directed self-checking bench for tap_exe_mc (N_CH=8,
//               THR_W=14, THR_INIT=0x155).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_exe_mc;
  import tap_pkg::*;

  localparam int N_CH  = 8;
  localparam int THR_W = 14;
  localparam int CW    = THR_W + 4;

  localparam logic [17:0] INIT  = 18'h00155;
  localparam logic [17:0] B_GT  = 18'h04000;
  localparam logic [17:0] B_ET  = 18'h08000;
  localparam logic [17:0] B_TRG = 18'h20000;
  localparam logic [31:0] EBIT  = 32'h0080_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic [31:0]       cmd;
  logic [31:0]       rsp;
  logic              rsp_valid;
  logic              busy;
  logic              ovf;
  logic [N_CH*CW-1:0] ctl;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [17:0] e [N_CH];

  tap_exe_mc #(
    .N_CH     (N_CH),
    .THR_W    (THR_W),
    .THR_INIT ('h155)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .cmd       (cmd),
    .rsp       (rsp),
    .rsp_valid (rsp_valid),
    .busy      (busy),
    .ovf       (ovf),
    .ctl       (ctl)
  );

  always #5 clk = ~clk;

  function automatic logic [N_CH*CW-1:0] flat();
    logic [N_CH*CW-1:0] f;
    for (int k = 0; k < N_CH; k++) f[k*CW +: CW] = e[k];
    return f;
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] ins, input logic [6:0] c, input logic [15:0] v);
    return {C_TAP, ins, 1'b0, c, v};
  endfunction

  task automatic check(input string tag, input logic [N_CH*CW-1:0] obs, input logic [N_CH*CW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] c);
    run = 1'b1;
    cmd = c;
    tick();
    run = 1'b0;
    cmd = '0;
  endtask

  initial begin : main
    logic [31:0] c;
    logic [31:0] cb;
    logic        saw_valid;

    rst = 1'b1;
    run = 1'b0;
    cmd = '0;
    for (int k = 0; k < N_CH; k++) e[k] = INIT;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset_ctl", ctl, flat());
    check("reset_rsp", rsp, 0);
    check("reset_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_ovf", ovf, 0);

    // SET_THR ch3, then GET_THR ch3 back-to-back
    c = mk(I_SET_THR, 7'd3, 16'h1ABC);
    issue(c);
    e[3] = 18'h01ABC;
    check("set_thr_ctl", ctl, flat());
    check("set_thr_valid", rsp_valid, 1);
    check("set_thr_rsp", rsp, c);
    c = mk(I_GET_THR, 7'd3, 16'h0000);
    issue(c);
    check("get_thr_valid", rsp_valid, 1);
    check("get_thr_rsp", rsp, {c[31:16], 16'h1ABC});
    tick();
    check("idle_valid", rsp_valid, 0);
    check("idle_rsp_hold", rsp, {c[31:16], 16'h1ABC});

    // Flags on ch1
    c = mk(I_SET_GT, 7'd1, 16'h0001);
    issue(c);
    e[1] = 18'h04155;
    check("set_gt_ctl", ctl, flat());
    check("set_gt_rsp", rsp, c);
    c = mk(I_SET_LT, 7'd1, 16'hFFFF);
    issue(c);
    e[1] = 18'h14155;
    check("set_lt_ctl", ctl, flat());
    c = mk(I_GET_FLAGS, 7'd1, 16'h0000);
    issue(c);
    check("get_flags_rsp", rsp, {c[31:16], 16'h0005});

    // Error cases
    c = {C_TAP, 4'd9, 1'b0, 7'd2, 16'h0001};
    issue(c);
    check("err_instr_rsp", rsp, c | EBIT);
    check("err_instr_valid", rsp_valid, 1);
    check("err_instr_ctl", ctl, flat());
    c = mk(I_SET_GT, 7'd8, 16'h0001);
    issue(c);
    check("err_ch_rsp", rsp, c | EBIT);
    check("err_ch_ctl", ctl, flat());
    c = mk(I_GET_FLAGS, 7'h7F, 16'h0000);
    issue(c);
    check("err_get_bc_rsp", rsp, c | EBIT);
    check("err_get_bc_ctl", ctl, flat());

    // Foreign target is ignored
    issue({4'h5, I_SET_GT, 1'b0, 7'd0, 16'h0001});
    check("foreign_valid", rsp_valid, 0);
    check("foreign_ctl", ctl, flat());
    check("foreign_rsp_hold", rsp, c | EBIT);

    // RESET_CH ch1
    c = mk(I_RESET_CH, 7'd1, 16'h0000);
    issue(c);
    e[1] = INIT;
    check("reset_ch_ctl", ctl, flat());
    check("reset_ch_rsp", rsp, c);

    // Broadcast SET_TRIG_EN
    cb = mk(I_SET_TRIG_EN, 7'h7F, 16'h0001);
    issue(cb);
    check("bc1_e0_busy", busy, 1);
    check("bc1_e0_valid", rsp_valid, 0);
    check("bc1_e0_ctl", ctl, flat());
    for (int k = 0; k < N_CH; k++) begin
      tick();
      e[k] = e[k] | B_TRG;
      check("bc1_ctl", ctl, flat());
      if (k < N_CH - 1) begin
        check("bc1_busy", busy, 1);
        check("bc1_no_valid", rsp_valid, 0);
      end else begin
        check("bc1_end_busy", busy, 0);
        check("bc1_end_valid", rsp_valid, 1);
        check("bc1_end_rsp", rsp, cb);
      end
    end
    tick();
    check("bc1_single_valid", rsp_valid, 0);

    // Broadcast SET_ET with a command dropped mid-sweep
    cb = mk(I_SET_ET, 7'h7F, 16'h0001);
    issue(cb);
    for (int k = 0; k < N_CH; k++) begin
      if (k == 2) begin
        run = 1'b1;
        cmd = mk(I_SET_THR, 7'd0, 16'h3FFF);
      end
      tick();
      run = 1'b0;
      cmd = '0;
      e[k] = e[k] | B_ET;
      if (k == 2) check("drop_ovf", ovf, 1);
    end
    check("bc2_ctl", ctl, flat());
    check("bc2_busy", busy, 0);
    check("bc2_valid", rsp_valid, 1);
    check("bc2_rsp", rsp, cb);
    c = mk(I_GET_FLAGS, 7'd7, 16'h0000);
    issue(c);
    check("accept_at_fall_valid", rsp_valid, 1);
    check("accept_at_fall_rsp", rsp, {c[31:16], 16'h000A});
    repeat (3) tick();
    check("ovf_sticky", ovf, 1);

    // Reset in the middle of a broadcast
    issue(mk(I_SET_GT, 7'h7F, 16'h0001));
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < N_CH; k++) e[k] = INIT;
    check("midrst_ctl", ctl, flat());
    check("midrst_busy", busy, 0);
    check("midrst_valid", rsp_valid, 0);
    check("midrst_ovf", ovf, 0);
    c = mk(I_SET_GT, 7'd0, 16'h0001);
    issue(c);
    e[0] = INIT | B_GT;
    check("post_rst_ctl", ctl, flat());
    check("post_rst_valid", rsp_valid, 1);
    check("post_rst_rsp", rsp, c);
    saw_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (rsp_valid) saw_valid = 1'b1;
    end
    check("midrst_no_late_rsp", saw_valid, 0);
    check("post_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tap_exe_mc.md
# tap_exe_mc

Multi-channel successor to the single-channel trigger-tap command executor. It sits on the command bus after the command decoder and holds per-channel discriminator controls: GT/ET/LT comparator enables, threshold, and trigger enable. It serves set, readback, per-channel reset and broadcast commands, each with a response word and a valid strobe. Broadcast writes are sequenced one channel per cycle; `busy` flags the sequence to upstream.

## Interface
- `N_CH`, default 8: channel count, 1..127.
- `THR_W`, default 14: threshold width, 1..16.
- `THR_INIT`, default 0: threshold value after reset or RESET_CH.
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `run`, in, 1: one-cycle command strobe.
- `cmd`, in, 32: command word; sampled when `run`=1.
- `rsp`, out, 32: response word.
- `rsp_valid`, out, 1: one-cycle strobe; `rsp` is valid while it is high.
- `busy`, out, 1: broadcast sweep in progress.
- `ovf`, out, 1: sticky; set when a command is dropped because `run` arrived while `busy`=1.
- `ctl`, out, N_CH*(THR_W+4): flattened per-channel controls. Channel k occupies slice [k*(THR_W+4) +: THR_W+4], packed as {trig_en, lt, et, gt, thr}.

## Operation
- Command fields:
  - target `cmd[31:28]`; only C_TAP is accepted, and all other targets are ignored with no response.
  - instr `cmd[27:24]`.
  - channel `cmd[22:16]`.
  - value `cmd[15:0]`.
  - `cmd[23]` is unused on input.
- Instructions:
  - 0 SET_GT: gt=value[0].
  - 1 SET_ET: et=value[0].
  - 2 SET_LT: lt=value[0].
  - 3 SET_THR: thr=value[THR_W-1:0].
  - 4 SET_TRIG_EN: trig_en=value[0].
  - 5 GET_THR.
  - 6 GET_FLAGS: returns {12'b0, trig_en, lt, et, gt}.
  - 7 RESET_CH: flags=0, thr=THR_INIT.
- Response construction:
  - Success on a SET or RESET_CH: `rsp`=`cmd` with bit 23 cleared.
  - Success on a GET: `rsp`=`cmd[31:16]` followed by the zero-extended readback in `rsp[15:0]`.
  - Error: `rsp`=`cmd` with bit 23 set; no state change.
- Error cases:
  - instr 8..15.
  - channel ≥ N_CH and channel ≠ 7'h7F.
  - GET with channel 7'h7F.
- Broadcast (channel 7'h7F) applies SET_* or RESET_CH to every channel in turn.
- Reset values:
  - each channel: flags 0, thr=THR_INIT.
  - `rsp`=0, `rsp_valid`=0, `busy`=0, `ovf`=0.
- FSM states:
  - IDLE, on `run` & C_TAP:
    - single-channel or error command: execute, then stay in IDLE.
    - broadcast command: latch instr and value, idx=0, go to SWEEP.
  - SWEEP: each cycle write channel idx and increment idx. After the write at idx=N_CH-1, issue the response and return to IDLE.
- While in SWEEP, `run` with any target is dropped: no response, and `ovf`←1. `ovf` clears only on `rst`.
- `rst` mid-sweep: everything returns to reset values at that edge, and no response is issued.

## Timing
- Notation: E0 is the edge where `run` is sampled.
- Single-channel command:
  - `ctl` is updated at E0.
  - `rsp`/`rsp_valid` are valid in the cycle after E0, so latency is 1.
- GET returns the value as it stood before E0.
- Broadcast:
  - `busy`=1 from E0 through E_N (N_CH cycles).
  - Channel k is written at edge E(k+1).
  - `rsp_valid` goes high in the cycle after E_N_CH.
  - `busy` drops at the same edge `rsp_valid` rises.
- Back-to-back single commands are accepted every cycle. `rsp_valid` then stays high, with `rsp` updated each cycle.
- `run` is accepted in the same cycle that `busy` falls.
- `rsp` holds its last value when `rsp_valid`=0.

## Structure
- Shared package `tap_pkg` holds:
  - C_TAP target code and instr codes 0..7.
  - C_TAP_BCAST=7'h7F and field bit positions.
  - error bit index 23.
  - `ctl` slice layout constants and get/set helpers.
- Sub-module `tap_ch_reg`, instantiated N_CH times:
  - ports `clk`, `rst`, `we`, `sel` (3-bit instr), `val`, `ctl_o`.
  - it owns the reset and RESET_CH behaviour.
- Top level holds the FSM, idx counter, decode, readback mux, response and `ovf`.

## Test plan
- Reset → every ctl slice={0,0,0,0,THR_INIT}; `rsp`=0, `busy`=0, `ovf`=0.
- SET_THR ch3 value 0x1ABC (THR_W=14) → ch3 thr=0x1ABC, other channels unchanged, `rsp_valid` one cycle later with bit23=0. A following GET_THR ch3 → `rsp[15:0]`=0x1ABC.
- Broadcast SET_TRIG_EN value 1 with N_CH=8 → `busy` high for 8 cycles and ch k trig_en rises at E(k+1). A single `rsp_valid` follows the last write.
- Error cases, each giving `rsp` bit23=1 with `ctl` unchanged:
  - instr 9.
  - channel 8 with N_CH=8.
  - GET_FLAGS with channel 7'h7F.
- `run` during a sweep → command dropped, `ovf`=1 until `rst`. The sweep still completes all 8 channels.
- `rst` asserted at E3 of a sweep → all channels reset, `busy`=0, no `rsp_valid`. A SET_GT ch0 issued next cycle executes normally.
